// File: rtl/seg7_hex_scan_if.sv
// ---------------------------------------------------------------------------
// seg7_hex_scan_if
//   Groups the data inputs and display outputs of seg7_hex_scan.
//   master : the side that drives the value/control signals (ALU or testbench)
//   slave  : the display scanner
//   Signals:
//     value    32  ALU result; digit i shows value[4i+3:4i]
//     load      1  snapshot strobe
//     blank_lz  1  blank leading zero digits when 1
//     dp_en     8  decimal-point enable per digit, active high
//     AN        8  anode selects, active low
//     SEG       7  {CG,CF,CE,CD,CC,CB,CA}, active low
//     DP        1  decimal point, active low
// ---------------------------------------------------------------------------
interface seg7_hex_scan_if;
  logic [31:0] value;
  logic        load;
  logic        blank_lz;
  logic [7:0]  dp_en;
  logic [7:0]  AN;
  logic [6:0]  SEG;
  logic        DP;

  modport master (
    output value, load, blank_lz, dp_en,
    input  AN, SEG, DP
  );

  modport slave (
    input  value, load, blank_lz, dp_en,
    output AN, SEG, DP
  );
endinterface

// File: rtl/seg7_hex_scan.sv
// ---------------------------------------------------------------------------
// seg7_hex_scan
//   Shows a latched 32-bit value as 8 hex digits on a multiplexed,
//   common-anode 7-segment display. Each digit slot starts with a short
//   dark guard interval (all anodes off) so a digit change never ghosts
//   into its neighbour. Leading zero digits can optionally be blanked.
//   Ports:
//     CLK100MHZ   in   system clock
//     CPU_RESETN  in   asynchronous reset, active low
//     bus         slave modport of seg7_hex_scan_if (value, load,
//                 blank_lz, dp_en in; AN, SEG, DP out, all registered)
// ---------------------------------------------------------------------------
module seg7_hex_scan #(
  parameter int REFRESH_DIV  = 100000,
  parameter int GUARD_CYCLES = 64
) (
  input  logic           CLK100MHZ,
  input  logic           CPU_RESETN,
  seg7_hex_scan_if.slave bus
);

  localparam int PW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int GW = $clog2(GUARD_CYCLES + 1);

  // Hex nibble to active-low segment pattern {G,F,E,D,C,B,A}.
  function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
    logic [6:0] seg;
    case (nib)
      4'h0:    seg = 7'h40;
      4'h1:    seg = 7'h79;
      4'h2:    seg = 7'h24;
      4'h3:    seg = 7'h30;
      4'h4:    seg = 7'h19;
      4'h5:    seg = 7'h12;
      4'h6:    seg = 7'h02;
      4'h7:    seg = 7'h78;
      4'h8:    seg = 7'h00;
      4'h9:    seg = 7'h10;
      4'hA:    seg = 7'h08;
      4'hB:    seg = 7'h03;
      4'hC:    seg = 7'h46;
      4'hD:    seg = 7'h21;
      4'hE:    seg = 7'h06;
      4'hF:    seg = 7'h0E;
      default: seg = 7'h7F;
    endcase
    return seg;
  endfunction

  logic [31:0]   snap_r;
  logic [PW-1:0] presc_r;
  logic [2:0]    dig_r;
  logic [GW-1:0] guard_r;
  logic [7:0]    an_r;
  logic [6:0]    seg_r;
  logic          dp_r;

  logic [4:0]    shamt_s;
  logic [31:0]   upper_s;
  logic [3:0]    nibble_s;
  logic          blank_s;
  logic [7:0]    an_s;
  logic [6:0]    seg_s;
  logic          dp_s;

  // Snapshot register: the display only ever reads this copy of value.
  always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
    if (!CPU_RESETN) begin
      snap_r <= 32'd0;
    end else if (bus.load) begin
      snap_r <= bus.value;
    end else begin
      snap_r <= snap_r;
    end
  end

  // Slot timing: prescaler, digit index and the per-slot dark guard counter.
  always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
    if (!CPU_RESETN) begin
      presc_r <= '0;
      dig_r   <= 3'd0;
      guard_r <= GW'(GUARD_CYCLES);
    end else if (presc_r == PW'(REFRESH_DIV - 1)) begin
      presc_r <= '0;
      dig_r   <= dig_r + 3'd1;
      guard_r <= GW'(GUARD_CYCLES);
    end else begin
      presc_r <= presc_r + PW'(1);
      dig_r   <= dig_r;
      if (guard_r != '0) begin
        guard_r <= guard_r - GW'(1);
      end else begin
        guard_r <= guard_r;
      end
    end
  end

  // Next display pattern from the current digit, guard state and snapshot.
  // A digit above 0 is blanked when everything from it upward is zero.
  always_comb begin
    shamt_s  = {dig_r, 2'b00};
    upper_s  = snap_r >> shamt_s;
    nibble_s = upper_s[3:0];
    blank_s  = (dig_r != 3'd0) && bus.blank_lz && (upper_s == 32'd0);
    an_s     = 8'hFF;
    seg_s    = 7'h7F;
    dp_s     = 1'b1;
    if ((guard_r != '0) || blank_s) begin
      an_s  = 8'hFF;
      seg_s = 7'h7F;
      dp_s  = 1'b1;
    end else begin
      an_s  = ~(8'd1 << dig_r);
      seg_s = hex_to_seg(nibble_s);
      dp_s  = ~bus.dp_en[dig_r];
    end
  end

  // Output registers keep AN/SEG/DP glitch-free between clock edges.
  always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
    if (!CPU_RESETN) begin
      an_r  <= 8'hFF;
      seg_r <= 7'h7F;
      dp_r  <= 1'b1;
    end else begin
      an_r  <= an_s;
      seg_r <= seg_s;
      dp_r  <= dp_s;
    end
  end

  assign bus.AN  = an_r;
  assign bus.SEG = seg_r;
  assign bus.DP  = dp_r;

endmodule

// File: tb/tb_seg7_hex_scan.sv
// ---------------------------------------------------------------------------
// tb_seg7_hex_scan
//   Scoreboard bench for seg7_hex_scan with REFRESH_DIV=4, GUARD_CYCLES=1.
//   The driver pushes the expected display pattern for each upcoming clock
//   edge, computed from elapsed time since reset, the snapshot contents and
//   the hex table; a separate monitor pops and compares after every edge.
// ---------------------------------------------------------------------------
module tb_seg7_hex_scan;
  localparam int R = 4;
  localparam int G = 1;

  typedef struct packed {
    logic [7:0] an;
    logic [6:0] seg;
    logic       dp;
  } out_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  seg7_hex_scan_if bus();

  seg7_hex_scan #(.REFRESH_DIV(R), .GUARD_CYCLES(G)) dut (
    .CLK100MHZ (clk),
    .CPU_RESETN(rst_n),
    .bus       (bus)
  );

  out_t        exp_q[$];
  int          n_cmp = 0;
  int          n_err = 0;
  int          t     = 0;     // clocks since reset release
  logic [31:0] m_snap = 32'd0;
  logic [31:0] cur_val = 32'd0;
  logic        cur_blz = 1'b0;
  logic [7:0]  cur_dp  = 8'd0;

  logic [6:0] hex_seg [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                               7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  // Display pattern expected after tt clocks have elapsed since reset.
  function automatic out_t model(int tt, logic [31:0] s, logic blz, logic [7:0] dpen);
    int   d;
    int   pos;
    out_t o;
    logic [31:0] up;
    d   = (tt / R) % 8;
    pos = tt % R;
    up  = s >> (4 * d);
    o   = {8'hFF, 7'h7F, 1'b1};
    if (pos >= G && !(d != 0 && blz && up == 32'd0)) begin
      o.an  = 8'hFF ^ (8'd1 << d);
      o.seg = hex_seg[up & 32'd15];
      o.dp  = ~dpen[d];
    end
    return o;
  endfunction

  task automatic drive_push(input logic [31:0] v, input logic ld, input logic blz,
                            input logic [7:0] dpen);
    bus.value    = v;
    bus.load     = ld;
    bus.blank_lz = blz;
    bus.dp_en    = dpen;
    cur_val = v; cur_blz = blz; cur_dp = dpen;
    exp_q.push_back(model(t, m_snap, blz, dpen));
    if (ld) m_snap = v;
    t++;
  endtask

  task automatic step(input logic [31:0] v, input logic ld, input logic blz,
                      input logic [7:0] dpen);
    @(negedge clk);
    drive_push(v, ld, blz, dpen);
  endtask

  task automatic hold(input int n);
    for (int i = 0; i < n; i++) step(cur_val, 1'b0, cur_blz, cur_dp);
  endtask

  task automatic check_reset(input string name);
    n_cmp++;
    if ({bus.AN, bus.SEG, bus.DP} !== {8'hFF, 7'h7F, 1'b1}) begin
      n_err++;
      $display("FAIL %s: got AN=%h SEG=%h DP=%b, want AN=ff SEG=7f DP=1",
               name, bus.AN, bus.SEG, bus.DP);
    end
  endtask

  task automatic release_reset();
    @(negedge clk);
    rst_n  = 1'b1;
    t      = 0;
    m_snap = 32'd0;
    drive_push(cur_val, 1'b0, cur_blz, cur_dp);
  endtask

  // Monitor: compare every post-edge output against the scoreboard.
  initial begin
    out_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        n_cmp++;
        if ({bus.AN, bus.SEG, bus.DP} !== e) begin
          n_err++;
          $display("FAIL scan @%0t: got AN=%h SEG=%h DP=%b, want AN=%h SEG=%h DP=%b",
                   $time, bus.AN, bus.SEG, bus.DP, e.an, e.seg, e.dp);
        end
        n_cmp++;
        if ($countones(~bus.AN) > 1) begin
          n_err++;
          $display("FAIL onehot @%0t: got AN=%h, want at most one low bit", $time, bus.AN);
        end
      end
    end
  end

  initial begin
    logic [31:0] rv;
    bus.value = 32'd0; bus.load = 1'b0; bus.blank_lz = 1'b0; bus.dp_en = 8'd0;
    #12;
    check_reset("reset_init");
    release_reset();

    // Scan order and decode over two full frames plus wrap.
    step(32'h89AB_CDEF, 1'b1, 1'b0, 8'h00);
    hold(2 * 8 * R + 4);

    // Leading-zero blanking.
    step(32'h0000_0003, 1'b1, 1'b1, 8'h00);
    hold(8 * R + 4);
    step(32'h0000_0000, 1'b1, 1'b1, 8'h00);
    hold(8 * R + 4);

    // Snapshot hold, then a one-clock load.
    step(32'hFFFF_FFFF, 1'b0, 1'b0, 8'h00);
    hold(2 * 8 * R);
    step(32'hFFFF_FFFF, 1'b1, 1'b0, 8'h00);
    hold(8 * R + 4);

    // Load coincident with the digit 2 -> 3 slot change.
    step(32'h1111_1111, 1'b1, 1'b0, 8'h00);
    while (!((t % R == R - 1) && ((t / R) % 8 == 2))) hold(1);
    step(32'h2222_2222, 1'b1, 1'b0, 8'h00);
    hold(8 * R + 4);

    // Decimal point on digit 4 only.
    step(32'h2222_2222, 1'b0, 1'b0, 8'h10);
    hold(8 * R + 4);

    // Reset mid-slot on digit 5, outputs go dark without a clock.
    while (!((t % R == 2) && ((t / R) % 8 == 5))) hold(1);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1 check_reset("reset_async");
    #20 check_reset("reset_hold");
    release_reset();
    hold(8 * R + 4);

    // Randomized inputs with frequent leading zeros.
    for (int i = 0; i < 600; i++) begin
      rv = $urandom >> (4 * $urandom_range(0, 8));
      step(rv, ($urandom_range(0, 11) == 0), ($urandom_range(0, 3) != 0),
           8'($urandom_range(0, 255)));
    end

    @(negedge clk);
    @(negedge clk);
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL drain: got %0d pending, want 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
